cim_result_streamer: RTL and testbench

Reads a contiguous window of the CIM intermediate-result memory and transmits it word by word over a valid/ready stream to the host/output interface. It is the read-out counterpart of the centralized CIM core, which writes intermediate results into that memory. It sits between the int_res memory read port and the chip output link. It supports back-pressure, memory address wrap-around and abort.

---
 rtl/cim_result_streamer_if.sv | 31 +++
 rtl/cim_result_streamer.sv | 177 +++++++++++++++++
 tb/tb_cim_result_streamer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : cim_result_streamer_if
// Description : Memory read port plus output stream bundle for the CIM
//               result streamer. master = streamer side, slave = memory and
//               sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cim_result_streamer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (
        output mem_rd_en, mem_rd_addr, tx_data, tx_valid, tx_last,
        input  mem_rd_data, tx_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, tx_data, tx_valid, tx_last,
        output mem_rd_data, tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/cim_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : cim_result_streamer
// Description : Reads a contiguous (wrapping) window of the int_res memory
//               and streams it word by word over valid/ready, with a 2-entry
//               output buffer, back-pressure and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module cim_result_streamer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    cim_result_streamer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [2:0]      c_fifo_depth = 3'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] c_cnt_one    = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_tx_cnt;
    logic [ADDR_W:0]   w_len_ext;
    logic [ADDR_W:0]   w_len_m1;
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_tx_valid;
    logic              w_pop;
    logic              w_rd_en;
    logic              w_start_ok;
    logic              w_last_rd;
    logic              w_drained;
    logic [2:0]        w_occ;

    assign w_len_ext  = {1'b0, r_len};
    // len=0 gives all-ones here, which tx_cnt never reaches while valid.
    assign w_len_m1   = w_len_ext - c_cnt_one;
    assign w_tx_valid = (r_count != 2'd0);
    assign w_pop      = w_tx_valid & bus.tx_ready;
    assign w_start_ok = (r_state == ST_IDLE) & start & ~abort;

    // Occupancy the buffer will have once this cycle's pop and the pending
    // read return are accounted for; a read may issue only if it fits.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = (r_state == ST_READ) && (r_rd_cnt < w_len_ext)
                     && (w_occ < c_fifo_depth);
    assign w_last_rd = w_rd_en && (r_rd_cnt == w_len_m1);

    // Empty after this cycle: nothing in flight and the buffer is empty or
    // its last word is leaving now, so done lands right after the last beat.
    assign w_drained = ~r_inflight
                       && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

    // Next-state and status outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // len=0 passes through DRAIN so done arrives two cycles
                // after start like a normal completion.
                if (w_start_ok) begin
                    w_next_state = (len != '0) ? ST_READ : ST_DRAIN;
                end
            end
            ST_READ: begin
                busy = 1'b1;
                if (w_last_rd) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transfer window and progress counters; window is frozen while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_len    <= '0;
            r_rd_cnt <= '0;
            r_tx_cnt <= '0;
        end else if (w_start_ok) begin
            r_base   <= base_addr;
            r_len    <= len;
            r_rd_cnt <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + c_cnt_one;
            end
            if (w_pop) begin
                r_tx_cnt <= r_tx_cnt + c_cnt_one;
            end
        end
    end

    // Two-entry output buffer fed by the one-cycle memory read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else if (abort) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= bus.mem_rd_data;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
            r_inflight <= w_rd_en;
        end
    end

    assign bus.mem_rd_en   = w_rd_en;
    assign bus.mem_rd_addr = r_base + r_rd_cnt[ADDR_W-1:0];
    assign bus.tx_valid    = w_tx_valid;
    assign bus.tx_data     = w_tx_valid ? r_fifo[r_rd_ptr] : '0;
    assign bus.tx_last     = w_tx_valid && (r_tx_cnt == w_len_m1);

endmodule
`default_nettype wire

// File: tb/tb_cim_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cim_result_streamer
// Description : Directed self-checking bench for cim_result_streamer with a
//               queue-based reference model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cim_result_streamer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] len       = '0;
    logic        busy;
    logic        done;

    cim_result_streamer_if #(.DATA_W(16), .ADDR_W(12)) bus ();

    cim_result_streamer #(.DATA_W(16), .ADDR_W(12), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Memory holds its own address as data; one-cycle read latency.
    initial bus.mem_rd_data = '0;
    initial bus.tx_ready    = 1'b0;
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= 16'(bus.mem_rd_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_seq(input string name, input logic [15:0] got[$], input logic [15:0] want[$]);
        chk({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size() && i < got.size(); i++) chk(name, got[i], want[i]);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    logic [11:0] m_base     = '0;
    int          m_len      = 0;
    int          m_issued   = 0;
    int          m_hs       = 0;
    bit          m_active   = 0;
    bit          prev_stall = 0;
    bit          prev_done  = 0;
    logic [15:0] prev_data  = '0;
    int          c0         = 0;
    int          off;
    int          done_cyc   = -1;
    logic        busy_at [16];
    logic [15:0] hs_dat[$];
    logic [15:0] hs_last[$];
    int          hs_cyc[$];
    logic [15:0] rd_addr_log[$];
    int          rd_cyc[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; exp_q.delete(); m_issued = 0; m_hs = 0; m_len = 0;
            prev_stall = 0; prev_done = 0;
        end else begin
            off = cyc - c0;
            if (off >= 0 && off < 16) busy_at[off] = busy;
            if (prev_done) chk("busy_after_done", busy, 0);
            prev_done = done;

            if (bus.tx_valid) begin
                if (exp_q.size() == 0) chk("tx_valid_unexpected", 1, 0);
                else begin
                    chk("tx_data", bus.tx_data, exp_q[0]);
                    chk("tx_last", bus.tx_last, exp_q.size() == 1);
                end
            end else begin
                chk("tx_last_without_valid", bus.tx_last, 0);
            end
            if (prev_stall) begin
                chk("hold_valid", bus.tx_valid, 1);
                chk("hold_data", bus.tx_data, prev_data);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;

            chk("buffered_le2", (m_issued - m_hs) <= 2, 1);
            if (bus.mem_rd_en) begin
                if (!m_active || m_issued >= m_len) chk("mem_rd_en_unexpected", 1, 0);
                else chk("mem_rd_addr", bus.mem_rd_addr, 12'(m_base + 12'(m_issued)));
                rd_addr_log.push_back(16'(bus.mem_rd_addr));
                rd_cyc.push_back(cyc - c0);
                m_issued++;
            end

            if (done) begin
                chk("done_when_drained", m_active && exp_q.size() == 0 && m_issued == m_len, 1);
                m_active = 0;
                done_cyc = cyc - c0;
            end

            if (bus.tx_valid && bus.tx_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                m_hs++;
                hs_dat.push_back(bus.tx_data);
                hs_last.push_back(16'(bus.tx_last));
                hs_cyc.push_back(cyc - c0);
            end

            if (abort) begin
                m_active = 0; exp_q.delete(); m_issued = 0; m_hs = 0; m_len = 0;
                prev_stall = 0;
            end else if (start && !m_active) begin
                m_base = base_addr; m_len = int'(len); m_issued = 0; m_hs = 0;
                exp_q.delete();
                for (int i = 0; i < m_len; i++) exp_q.push_back(16'(12'(base_addr + 12'(i))));
                m_active = 1;
                c0 = cyc; done_cyc = -1;
                foreach (busy_at[i]) busy_at[i] = 1'bx;
                hs_dat.delete(); hs_last.delete(); hs_cyc.delete();
                rd_addr_log.delete(); rd_cyc.delete();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [11:0] b, input logic [11:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 12'hA5A; len = 12'h3C3;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int t = 0;
        while (done_cyc < 0 && t < budget) begin
            @(posedge clk); #1;
            if (toggle) bus.tx_ready = ~bus.tx_ready;
            t++;
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
    endtask

    task automatic check_outputs_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
        chk({tag, "_tx_valid"}, bus.tx_valid, 0);
        chk({tag, "_tx_last"}, bus.tx_last, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
    endtask

    task automatic run_basic(input string tag);
        logic [15:0] want[$];
        int          want_cyc[4] = '{3, 4, 5, 6};
        bus.tx_ready = 1'b1;
        do_start(12'h010, 12'd4);
        wait_done(40, 0);
        want = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        check_seq({tag, "_data"}, hs_dat, want);
        want = '{16'h0000, 16'h0000, 16'h0000, 16'h0001};
        check_seq({tag, "_last"}, hs_last, want);
        for (int i = 0; i < 4 && i < hs_cyc.size(); i++) chk({tag, "_beat_cycle"}, hs_cyc[i], want_cyc[i]);
        chk({tag, "_done_cycle"}, done_cyc, 7);
        chk({tag, "_busy_n1"}, busy_at[1], 1);
        chk({tag, "_first_rd_cycle"}, (rd_cyc.size() > 0) ? rd_cyc[0] : -1, 1);
        chk({tag, "_first_rd_addr"}, (rd_addr_log.size() > 0) ? rd_addr_log[0] : 16'hFFFF, 16'h0010);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] want[$];
        int          t;

        // Reset state
        #1;
        check_outputs_reset("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic transfer
        run_basic("basic");

        // Back-pressure with tx_ready toggling every cycle
        bus.tx_ready = 1'b1;
        do_start(12'h000, 12'd8);
        wait_done(100, 1);
        want = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
        check_seq("bp_data", hs_dat, want);

        // Address wrap-around
        do_start(12'hFFE, 12'd4);
        wait_done(40, 0);
        want = '{16'h0FFE, 16'h0FFF, 16'h0000, 16'h0001};
        check_seq("wrap_addr", rd_addr_log, want);
        check_seq("wrap_data", hs_dat, want);

        // len = 0
        do_start(12'h123, 12'd0);
        wait_done(20, 0);
        chk("len0_done_cycle", done_cyc, 2);
        chk("len0_busy_n1", busy_at[1], 1);
        chk("len0_busy_n3", busy_at[3], 0);
        chk("len0_no_reads", rd_addr_log.size(), 0);
        chk("len0_no_beats", hs_dat.size(), 0);

        // Start while busy is ignored
        do_start(12'h020, 12'd5);
        do_start(12'h300, 12'd7);
        wait_done(40, 0);
        want = '{16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024};
        check_seq("busy_start_data", hs_dat, want);

        // Abort after three handshakes
        do_start(12'h040, 12'd6);
        t = 0;
        while (hs_dat.size() < 3 && t < 40) begin @(posedge clk); t++; end
        if (hs_dat.size() < 3) chk("abort_wait_timeout", 0, 1);
        #1;
        abort = 1'b1; bus.tx_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_tx_valid", bus.tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_beats", hs_dat.size(), 3);
        repeat (4) @(posedge clk);
        #1 bus.tx_ready = 1'b1;
        do_start(12'h100, 12'd2);
        wait_done(30, 0);
        want = '{16'h0100, 16'h0101};
        check_seq("post_abort_data", hs_dat, want);

        // Asynchronous reset mid-transfer
        do_start(12'h010, 12'd4);
        t = 0;
        while (!bus.tx_valid && t < 20) begin @(negedge clk); t++; end
        if (!bus.tx_valid) chk("areset_wait_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_reset("areset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_basic("after_reset");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
